// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared definitions for the sprite draw scheduler: FSM state encodings,
// screen/background defaults, the per-slot sprite record and the
// slot-entry decision helper.
package sprite_draw_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_ERASE = 3'd2,
    ST_DRAW  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int          DEF_SCREEN_W  = 160;
  localparam int          DEF_SCREEN_H  = 120;
  localparam logic [2:0]  DEF_BG_COLOUR = 3'b000;

  // One sprite slot as seen by the scheduler.
  typedef struct packed {
    logic       valid;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } slot_t;

  // First state for a slot: erase old box, else draw new box, else skip.
  function automatic state_e slot_entry(input logic erase, input logic draw);
    if (erase)     return ST_ERASE;
    else if (draw) return ST_DRAW;
    else           return ST_NEXT;
  endfunction

endpackage

// File: rtl/sprite_box_raster.sv
// Box rasteriser: walks px (inner) and py (outer) over an SPR_W x SPR_H
// box, one pixel per step, and reports the absolute pixel position, whether
// it lies on screen, and whether this is the last pixel of the box.
// Counters wrap to zero after the last pixel, so back-to-back passes need
// no extra clear cycle.
module sprite_box_raster #(
  parameter int SPR_W    = 4,
  parameter int SPR_H    = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       step,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  output logic [7:0] x_pix,
  output logic [6:0] y_pix,
  output logic       on_screen,
  output logic       last_pixel
);

  localparam logic [3:0] PX_LAST = 4'(SPR_W - 1);
  localparam logic [3:0] PY_LAST = 4'(SPR_H - 1);

  logic [3:0] px, py;
  logic [8:0] x_sum;
  logic [7:0] y_sum;

  // Raster-order pixel counters, cleared on start and wrapping after the box.
  always_ff @(posedge clk) begin
    if (!resetn || start) begin
      px <= '0;
      py <= '0;
    end else if (step) begin
      if (px == PX_LAST) begin
        px <= '0;
        py <= (py == PY_LAST) ? 4'd0 : py + 4'd1;
      end else begin
        px <= px + 4'd1;
      end
    end
  end

  // Widened sums so pixels past the right/bottom edge clip instead of wrapping.
  always_comb begin
    x_sum      = {1'b0, base_x} + {5'd0, px};
    y_sum      = {1'b0, base_y} + {4'd0, py};
    on_screen  = (x_sum < 9'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));
    last_pixel = (px == PX_LAST) && (py == PY_LAST);
    x_pix      = x_sum[7:0];
    y_pix      = y_sum[6:0];
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Per-frame sprite draw sequencer feeding the VGA framebuffer write port.
// On frame_tick all slots are snapshotted; each slot is then visited in
// index order: optional erase of the previous box, then draw of the new box.
// Optional feature macro: DRAW_ERASE_EN (erase pass with prev_* tracking).
// Without it, background clearing is left to another block.
module sprite_draw_scheduler
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int         N_SPRITES = 6,
  parameter int         SPR_W     = 4,
  parameter int         SPR_H     = 4,
  parameter int         SCREEN_W  = DEF_SCREEN_W,
  parameter int         SCREEN_H  = DEF_SCREEN_H,
  parameter logic [2:0] BG_COLOUR = DEF_BG_COLOUR
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic [N_SPRITES-1:0]   sprite_valid,
  input  logic [8*N_SPRITES-1:0] sprite_x,
  input  logic [7*N_SPRITES-1:0] sprite_y,
  input  logic [3*N_SPRITES-1:0] sprite_colour,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour,
  output logic                   plot,
  output logic                   busy,
  output logic [3:0]             slot_idx,
  output logic                   frame_overrun
);

  localparam int SW = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

  state_e                      state;
  slot_t [N_SPRITES-1:0]       in_slot;
  slot_t [N_SPRITES-1:0]       shadow;
  logic  [SW-1:0]              sel, nxt_sel;
  logic                        last_slot, in_pass;
  logic                        erase_first, erase_next;
  logic  [7:0]                 base_x, x_pix;
  logic  [6:0]                 base_y, y_pix;
  logic  [2:0]                 pass_colour;
  logic                        on_screen, last_pixel;

  for (genvar i = 0; i < N_SPRITES; i++) begin : g_unpack
    assign in_slot[i] = {sprite_valid[i], sprite_x[8*i +: 8],
                         sprite_y[7*i +: 7], sprite_colour[3*i +: 3]};
  end

  assign sel       = slot_idx[SW-1:0];
  assign last_slot = (slot_idx == 4'(N_SPRITES - 1));
  assign nxt_sel   = last_slot ? '0 : sel + 1'b1;
  assign in_pass   = (state == ST_ERASE) || (state == ST_DRAW);

`ifdef DRAW_ERASE_EN
  logic [N_SPRITES-1:0]      prev_valid;
  logic [N_SPRITES-1:0][7:0] prev_x;
  logic [N_SPRITES-1:0][6:0] prev_y;

  assign erase_first = prev_valid[0];
  assign erase_next  = prev_valid[nxt_sel];

  // Remember where each slot was drawn so the next frame can erase it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev_valid <= '0;
    end else if (state == ST_NEXT) begin
      prev_valid[sel] <= shadow[sel].valid;
      prev_x[sel]     <= shadow[sel].x;
      prev_y[sel]     <= shadow[sel].y;
    end
  end

  // Pass source: old box for erase, latched box for draw.
  always_comb begin
    base_x = shadow[sel].x;
    base_y = shadow[sel].y;
    if (state == ST_ERASE) begin
      base_x = prev_x[sel];
      base_y = prev_y[sel];
    end
  end
`else
  assign erase_first = 1'b0;
  assign erase_next  = 1'b0;

  // Pass source: only the latched box is ever drawn.
  always_comb begin
    base_x = shadow[sel].x;
    base_y = shadow[sel].y;
  end
`endif

  assign pass_colour = (state == ST_ERASE) ? BG_COLOUR : shadow[sel].colour;

  // Snapshot every slot once per frame so game logic can change mid-frame.
  always_ff @(posedge clk) begin
    if (state == ST_LATCH) shadow <= in_slot;
  end

  sprite_box_raster #(
    .SPR_W    (SPR_W),
    .SPR_H    (SPR_H),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_raster (
    .clk        (clk),
    .resetn     (resetn),
    .start      (state == ST_LATCH),
    .step       (in_pass),
    .base_x     (base_x),
    .base_y     (base_y),
    .x_pix      (x_pix),
    .y_pix      (y_pix),
    .on_screen  (on_screen),
    .last_pixel (last_pixel)
  );

  // Frame sequencer: latch, then per slot erase/draw/next, then done.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      slot_idx      <= '0;
      frame_overrun <= 1'b0;
    end else begin
      frame_overrun <= frame_tick && (state != ST_IDLE);
      case (state)
        ST_IDLE:  if (frame_tick) state <= ST_LATCH;
        ST_LATCH: begin
          slot_idx <= '0;
          state    <= slot_entry(erase_first, in_slot[0].valid);
        end
        ST_ERASE: if (last_pixel) state <= shadow[sel].valid ? ST_DRAW : ST_NEXT;
        ST_DRAW:  if (last_pixel) state <= ST_NEXT;
        ST_NEXT: begin
          if (last_slot) begin
            state <= ST_DONE;
          end else begin
            slot_idx <= slot_idx + 4'd1;
            state    <= slot_entry(erase_next, shadow[nxt_sel].valid);
          end
        end
        ST_DONE: begin
          slot_idx <= '0;
          state    <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Pixel port is driven straight from registered state and counters.
  always_comb begin
    busy   = (state != ST_IDLE);
    plot   = in_pass && on_screen;
    x      = in_pass ? x_pix : '0;
    y      = in_pass ? y_pix : '0;
    colour = in_pass ? pass_colour : '0;
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Scoreboard bench for sprite_draw_scheduler. A frame-level model expands
// every slot into the pixels it should plot and the frame's busy length;
// a monitor pops those as the DUT plots.
module tb_sprite_draw_scheduler;

  localparam int N = 6, W = 4, H = 4, SCR_W = 160, SCR_H = 120;
`ifdef DRAW_ERASE_EN
  localparam bit ERASE_EN = 1'b1;
`else
  localparam bit ERASE_EN = 1'b0;
`endif

  logic clk = 1'b0, resetn = 1'b0, frame_tick = 1'b0;
  logic [N-1:0]   sprite_valid;
  logic [8*N-1:0] sprite_x;
  logic [7*N-1:0] sprite_y;
  logic [3*N-1:0] sprite_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, frame_overrun;
  logic [3:0] slot_idx;

  bit sv[N];
  int sx[N], sy[N], sc[N];

  typedef struct { int x; int y; int c; int slot; } pix_t;
  pix_t exp_q[$];
  int   len_q[$];
  pix_t mon_e;

  int errors = 0, checks = 0, ov_cnt = 0, run = 0;
  bit mprev_v[N];
  int mprev_x[N], mprev_y[N];

  sprite_draw_scheduler dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .sprite_valid(sprite_valid), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_colour(sprite_colour), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .slot_idx(slot_idx), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    sprite_valid  = '0;
    sprite_x      = '0;
    sprite_y      = '0;
    sprite_colour = '0;
    for (int i = 0; i < N; i++) begin
      sprite_valid[i]      = sv[i];
      sprite_x[8*i +: 8]   = 8'(sx[i]);
      sprite_y[7*i +: 7]   = 7'(sy[i]);
      sprite_colour[3*i +: 3] = 3'(sc[i]);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_box(input int k, input int bx, input int by, input int c);
    for (int py = 0; py < H; py++)
      for (int px = 0; px < W; px++)
        if (bx + px < SCR_W && by + py < SCR_H)
          exp_q.push_back('{bx + px, by + py, c, k});
  endtask

  // Whole-frame expectation: pixels per slot and total busy cycles.
  task automatic model_frame();
    int cyc = 2;
    for (int k = 0; k < N; k++) begin
      if (ERASE_EN && mprev_v[k]) begin
        push_box(k, mprev_x[k], mprev_y[k], 0);
        cyc += W * H;
      end
      if (sv[k]) begin
        push_box(k, sx[k], sy[k], sc[k]);
        cyc += W * H;
      end
      cyc += 1;
      mprev_v[k] = sv[k];
      mprev_x[k] = sx[k];
      mprev_y[k] = sy[k];
    end
    len_q.push_back(cyc);
  endtask

  // Monitor: compare each plotted pixel and each busy window length.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      len_q.delete();
      run = 0;
    end else begin
      if (frame_overrun) ov_cnt++;
      if (plot) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel: unexpected plot x=%0d y=%0d c=%0d slot=%0d", x, y, colour, slot_idx);
        end else begin
          mon_e = exp_q.pop_front();
          if (int'(x) != mon_e.x || int'(y) != mon_e.y || int'(colour) != mon_e.c ||
              int'(slot_idx) != mon_e.slot) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d) c=%0d slot=%0d expected (%0d,%0d) c=%0d slot=%0d",
                     x, y, colour, slot_idx, mon_e.x, mon_e.y, mon_e.c, mon_e.slot);
          end
        end
      end
      if (busy) run++;
      else if (run > 0) begin
        if (len_q.size() == 0) check("busy_len_unexpected", run, 0);
        else check("busy_len", run, len_q.pop_front());
        run = 0;
      end
    end
  end

  task automatic start_frame();
    model_frame();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("frame_timeout", n, 0);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic clear_slots();
    for (int i = 0; i < N; i++) begin
      sv[i] = 1'b0; sx[i] = 0; sy[i] = 0; sc[i] = 0;
    end
  endtask

  initial begin
    int ov_before, n;
    clear_slots();
    for (int i = 0; i < N; i++) mprev_v[i] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_xyc", {x, y, colour}, 0);
    check("rst_slot", slot_idx, 0);
    check("rst_overrun", frame_overrun, 0);
    @(posedge clk); #1 resetn = 1'b1;

    // Single player sprite, then moved by one pixel.
    sv[0] = 1'b1; sx[0] = 10; sy[0] = 20; sc[0] = 4;
    start_frame(); wait_frame();
    sx[0] = 11;
    start_frame(); wait_frame();

    // Bottom-right corner clipping on the bullet slot.
    sv[0] = 1'b0;
    sv[5] = 1'b1; sx[5] = 158; sy[5] = 118; sc[5] = 2;
    start_frame(); wait_frame();

    // Empty frame: only LATCH, N NEXT steps and DONE.
    clear_slots();
    start_frame(); wait_frame();

    // Tick while busy is dropped; mid-frame input change is ignored.
    sv[0] = 1'b1; sx[0] = 40; sy[0] = 30; sc[0] = 5;
    sv[3] = 1'b1; sx[3] = 100; sy[3] = 60; sc[3] = 3;
    ov_before = ov_cnt;
    start_frame();
    repeat (5) @(posedge clk);
    #1 frame_tick = 1'b1; sx[0] = 70; sx[3] = 20;
    @(posedge clk); #1 frame_tick = 1'b0;
    wait_frame();
    check("overrun_pulse", ov_cnt - ov_before, 1);
    repeat (3) @(negedge clk);
    check("no_restart_busy", busy, 0);

    // Randomised frames including partially and fully clipped sprites.
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < N; i++) begin
        sv[i] = 1'($urandom_range(0, 1));
        sx[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 159));
        sy[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 119));
        sc[i] = int'($urandom_range(0, 7));
      end
      start_frame(); wait_frame();
    end

    // Reset during slot 2 draw aborts the frame and forgets prev boxes.
    clear_slots();
    for (int i = 0; i < 3; i++) begin
      sv[i] = 1'b1; sx[i] = 20 * i + 5; sy[i] = 10 * i + 3; sc[i] = i + 1;
    end
    start_frame(); wait_frame();
    start_frame();
    n = 0;
    while (!(plot && slot_idx == 4'd2 && int'(colour) == sc[2]) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("slot2_draw_timeout", n, 0);
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_plot", plot, 0);
    check("abort_busy", busy, 0);
    for (int i = 0; i < N; i++) mprev_v[i] = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    start_frame(); wait_frame();

    check("overrun_total", ov_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
